fir_filter_seq: RTL and testbench

Sequential-MAC 16-tap low-pass FIR filter for 8-bit signed samples arriving at a fixed rate of one per `SAMPLE_PERIOD` clocks. Each captured sample enters a delay line. One tap product per clock is accumulated. The scaled result is registered onto `output_sig` well before the next sample arrives. The block sits between a sample source that holds each value stable for `SAMPLE_PERIOD` clocks and a downstream consumer that samples `output_sig` once per sample period.

---
 rtl/fir_filter_pkg.sv | 42 ++++
 rtl/fir_mac_unit.sv | 27 ++
 rtl/fir_filter_seq.sv | 93 +++++++++
 tb/tb_fir_filter_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fir_filter_pkg.sv
// Shared types, widths and coefficient table for the sequential-MAC FIR.
// FIR_SATURATE_EN selects a clamping output stage instead of a wrapping one.
package fir_filter_pkg;

    localparam int TAPS      = 16;
    localparam int DATA_W    = 8;
    localparam int ACC_W     = 20;
    localparam int COEF_FRAC = 7;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Symmetric Q1.7 low-pass taps; they sum to 128, so DC gain is one.
    localparam sample_t COEFS [TAPS] = '{
        8'sd1,  8'sd2,  8'sd3,  8'sd5,
        8'sd8,  8'sd11, 8'sd14, 8'sd20,
        8'sd20, 8'sd14, 8'sd11, 8'sd8,
        8'sd5,  8'sd3,  8'sd2,  8'sd1
    };

`ifdef FIR_SATURATE_EN
    localparam acc_t SAT_MAX = acc_t'((2 ** (DATA_W - 1)) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(2 ** (DATA_W - 1)));

    function automatic sample_t scale_out(input acc_t acc);
        acc_t sh;
        sh = acc >>> COEF_FRAC;
        if (sh > SAT_MAX) begin
            return sample_t'(SAT_MAX);
        end
        if (sh < SAT_MIN) begin
            return sample_t'(SAT_MIN);
        end
        return sample_t'(sh);
    endfunction
`else
    function automatic sample_t scale_out(input acc_t acc);
        return sample_t'(acc >>> COEF_FRAC);
    endfunction
`endif

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate; clear wins over enable.
// Products are formed at accumulator width so no bits are lost.
module fir_mac_unit
    import fir_filter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    en,
    input  sample_t sample,
    input  sample_t coef,
    output acc_t    acc
);

    acc_t product;

    assign product = acc_t'(sample) * acc_t'(coef);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + product;
        end
    end

endmodule

// File: rtl/fir_filter_seq.sv
// 16-tap FIR: phase counter sequences capture, one MAC per clock, then output.
// Output stage clamps when FIR_SATURATE_EN is defined, otherwise wraps.
module fir_filter_seq #(
    parameter int SAMPLE_PERIOD = 20,
    parameter int TAPS          = 16,
    parameter int DATA_W        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] input_sig,
    input  logic                     ready,
    output logic signed [DATA_W-1:0] output_sig
);

    import fir_filter_pkg::*;

    localparam int PH_W  = $clog2(SAMPLE_PERIOD);
    localparam int TAP_W = $clog2(TAPS);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLE_PERIOD - 1);
    localparam logic [PH_W-1:0] PH_EMIT = PH_W'(TAPS + 1);
    localparam logic [PH_W-1:0] PH_TAPS = PH_W'(TAPS);

    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_next;
    sample_t          delay [TAPS];
    logic [TAP_W-1:0] tap_idx;
    sample_t          tap_sample;
    sample_t          tap_coef;
    acc_t             acc;
    logic             capture;
    logic             tap_en;
    logic             emit;

    assign capture = ready && (phase == '0);
    assign tap_en  = ready && (phase != '0) && (phase <= PH_TAPS);
    assign emit    = ready && (phase == PH_EMIT);

    always_comb begin
        phase_next = phase + PH_W'(1);
        if (!ready || phase == PH_LAST) begin
            phase_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else begin
            phase <= phase_next;
        end
    end

    // Phase p (1..TAPS) works on tap p-1.
    always_comb begin
        tap_idx    = TAP_W'(phase - PH_W'(1));
        tap_sample = delay[tap_idx];
        tap_coef   = COEFS[tap_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                delay[k] <= '0;
            end
        end else if (capture) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                delay[k] <= delay[k-1];
            end
            delay[0] <= sample_t'(input_sig);
        end
    end

    // Dropping ready clears the accumulator, discarding a partial sum.
    fir_mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (!ready || capture),
        .en     (tap_en),
        .sample (tap_sample),
        .coef   (tap_coef),
        .acc    (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            output_sig <= '0;
        end else if (emit) begin
            output_sig <= DATA_W'(scale_out(acc));
        end
    end

endmodule

// File: tb/tb_fir_filter_seq.sv
// Randomised scoreboard bench for fir_filter_seq against an integer FIR model.
// Stimulus pushes expected outputs with due cycles; a monitor pops and compares.
module tb_fir_filter_seq;

    localparam int SP = 20;

    logic              clk;
    logic              rst;
    logic              ready;
    logic signed [7:0] input_sig;
    logic signed [7:0] output_sig;

    fir_filter_seq #(
        .SAMPLE_PERIOD (SP),
        .TAPS          (16),
        .DATA_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .input_sig  (input_sig),
        .ready      (ready),
        .output_sig (output_sig)
    );

    typedef struct {
        int                due;
        logic signed [7:0] val;
        string             tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int coef_tb [16] = '{1, 2, 3, 5, 8, 11, 14, 20, 20, 14, 11, 8, 5, 3, 2, 1};
    int imp_tb  [17] = '{0, 1, 2, 4, 7, 10, 13, 19, 19, 13, 10, 7, 4, 2, 1, 0, 0};
    int hist    [16];
    logic signed [7:0] last_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (e.due != cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d)",
                         e.tag, e.due, cyc);
            end else if (output_sig !== e.val) begin
                n_fail++;
                $display("FAIL %s at cycle %0d: output_sig=%0d, expected %0d",
                         e.tag, cyc, output_sig, e.val);
            end
        end
    end

    function automatic void sb_push(input int due, input logic signed [7:0] v,
                                    input string tag);
        exp_t e;
        e.due = due;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic void hist_push(input logic signed [7:0] v);
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(v);
    endfunction

    function automatic void hist_clear();
        for (int k = 0; k < 16; k++) hist[k] = 0;
    endfunction

    // Weighted sum, divided by 128 rounding toward minus infinity, clamped.
    function automatic logic signed [7:0] model_out();
        int s;
        int q;
        s = 0;
        for (int k = 0; k < 16; k++) s += coef_tb[k] * hist[k];
        if (s >= 0) q = s / 128;
        else q = -((-s + 127) / 128);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    // Called #1 after a rising edge with the phase counter at 0.
    task automatic send(input logic signed [7:0] v, input bit use_exp,
                        input logic signed [7:0] exp_v, input string tag);
        logic signed [7:0] m;
        input_sig = v;
        ready = 1'b1;
        hist_push(v);
        m = use_exp ? exp_v : model_out();
        sb_push(cyc + 18, m, tag);
        sb_push(cyc + 20, m, {tag, "_hold"});
        last_out = m;
        repeat (SP) @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic signed [7:0] v,
                          input string tag);
        for (int i = 0; i < n; i++) send(v, 1'b0, 8'sd0, tag);
    endtask

    task automatic reset_mid();
        input_sig = 8'sd77;
        ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        ready = 1'b0;
        sb_push(cyc + 1, 8'sd0, "rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        hist_clear();
        last_out = 8'sd0;
        sb_push(cyc + 3, 8'sd0, "rst_hold");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drop_ready(input logic signed [7:0] v);
        input_sig = v;
        ready = 1'b1;
        hist_push(v);
        repeat (10) @(posedge clk);
        #1;
        ready = 1'b0;
        sb_push(cyc + 8, last_out, "drop_hold");
        sb_push(cyc + 15, last_out, "drop_hold2");
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ready = 1'b0;
        input_sig = 8'sd0;
        hist_clear();
        last_out = 8'sd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_push(cyc, 8'sd0, "reset");

        for (int k = 1; k <= 50; k++) sb_push(cyc + k, 8'sd0, "idle");
        input_sig = 8'sd90;
        repeat (50) @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++)
            send((i == 0) ? 8'sd127 : 8'sd0, 1'b1, 8'(imp_tb[i]), "impulse");

        for (int i = 0; i < 20; i++)
            send(8'sd64, (i >= 15), 8'sd64, "dc64");
        send_n(20, 8'sd127, "pos_max");
        send(8'sd127, 1'b1, 8'sd127, "pos_max_steady");
        send_n(20, -8'sd128, "neg_max");
        send(-8'sd128, 1'b1, -8'sd128, "neg_max_steady");
        for (int i = 0; i < 20; i++)
            send((i % 2 == 0) ? 8'sd100 : -8'sd100, 1'b0, 8'sd0, "alt100");

        reset_mid();
        send_n(3, 8'sd50, "after_rst");

        for (int i = 0; i < 4; i++)
            send(8'($urandom_range(0, 255)), 1'b0, 8'sd0, "pre_drop");
        drop_ready(8'sd33);
        for (int i = 0; i < 4; i++)
            send(8'($urandom_range(0, 255)), 1'b0, 8'sd0, "post_drop");

        for (int i = 0; i < 400; i++)
            send(8'($urandom_range(0, 255)), 1'b0, 8'sd0, "random");

        for (int t = 0; t < 100 && sb.size() > 0; t++) @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d checks still pending, expected 0",
                     sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
